// File: rtl/execute_mem_stage_pkg.sv
// Shared types for the execute/memory stage: ALU ops, condition codes, flags and the E->M payload.
package execute_mem_stage_pkg;

    localparam int unsigned WIDTH = 32;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_op_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    typedef struct packed {
        logic             pcsrc;
        logic             regwrite;
        logic             memtoreg;
        logic             memwrite;
        logic [WIDTH-1:0] alu_result;
        logic [WIDTH-1:0] write_data;
        logic [3:0]       wa3;
    } em_reg_t;

endpackage

// File: rtl/execute_mem_stage_if.sv
// D->E inputs and E->M outputs of the execute stage; optional forwarding ports under EXEC_FORWARD_EN.
interface execute_mem_stage_if;
    import execute_mem_stage_pkg::*;

    logic             PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE;
    logic [1:0]       ALUControlE;
    logic [1:0]       FlagWriteE;
    logic [3:0]       CondE;
    logic [WIDTH-1:0] SrcAE, WriteDataE, ExtImmE;
    logic [3:0]       WA3E;
    logic             FlushE, StallM;
`ifdef EXEC_FORWARD_EN
    logic [1:0]       ForwardAE, ForwardBE;
    logic [WIDTH-1:0] ResultW;
`endif
    logic             BranchTakenE;
    logic [WIDTH-1:0] ALUResultE;
    logic [3:0]       FlagsQ;
    logic             PCSrcM, RegWriteM, MemtoRegM, MemWriteM;
    logic [WIDTH-1:0] ALUResultM, WriteDataM;
    logic [3:0]       WA3M;

    modport master (
        output PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE,
               ALUControlE, FlagWriteE, CondE, SrcAE, WriteDataE, ExtImmE, WA3E,
               FlushE, StallM,
`ifdef EXEC_FORWARD_EN
               ForwardAE, ForwardBE, ResultW,
`endif
        input  BranchTakenE, ALUResultE, FlagsQ,
               PCSrcM, RegWriteM, MemtoRegM, MemWriteM, ALUResultM, WriteDataM, WA3M
    );

    modport slave (
        input  PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE,
               ALUControlE, FlagWriteE, CondE, SrcAE, WriteDataE, ExtImmE, WA3E,
               FlushE, StallM,
`ifdef EXEC_FORWARD_EN
               ForwardAE, ForwardBE, ResultW,
`endif
        output BranchTakenE, ALUResultE, FlagsQ,
               PCSrcM, RegWriteM, MemtoRegM, MemWriteM, ALUResultM, WriteDataM, WA3M
    );

endinterface

// File: rtl/execute_mem_stage_cond_check.sv
// Combinational ARM condition evaluation against the current NZCV flags.
module execute_mem_stage_cond_check
    import execute_mem_stage_pkg::*;
(
    input  logic [3:0] cond_i,
    input  flags_t     flags_i,
    output logic       cond_ex_o
);

    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_i)
            COND_EQ: cond_ex_o = flags_i.z;
            COND_NE: cond_ex_o = ~flags_i.z;
            COND_CS: cond_ex_o = flags_i.c;
            COND_CC: cond_ex_o = ~flags_i.c;
            COND_MI: cond_ex_o = flags_i.n;
            COND_PL: cond_ex_o = ~flags_i.n;
            COND_VS: cond_ex_o = flags_i.v;
            COND_VC: cond_ex_o = ~flags_i.v;
            COND_HI: cond_ex_o = flags_i.c & ~flags_i.z;
            COND_LS: cond_ex_o = ~flags_i.c | flags_i.z;
            COND_GE: cond_ex_o = (flags_i.n == flags_i.v);
            COND_LT: cond_ex_o = (flags_i.n != flags_i.v);
            COND_GT: cond_ex_o = ~flags_i.z & (flags_i.n == flags_i.v);
            COND_LE: cond_ex_o = flags_i.z | (flags_i.n != flags_i.v);
            COND_AL: cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_mem_stage.sv
// Execute stage (ALU, condition check, NZCV register) plus the E->M pipeline register.
// Optional operand forwarding is enabled by defining EXEC_FORWARD_EN.
module execute_mem_stage
    import execute_mem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    execute_mem_stage_if.slave ex_if
);

    logic [WIDTH-1:0] src_a, src_b_reg, src_b, b_opnd, alu_result;
    logic [WIDTH:0]   sum;
    logic             is_sub;
    flags_t           alu_flags, flags_q, flags_d;
    logic             cond_ex, exec_en;
    em_reg_t          m_q, m_d;

`ifdef EXEC_FORWARD_EN
    // Operand select: 10 feeds back our own M result, 01 takes writeback.
    always_comb begin
        src_a = ex_if.SrcAE;
        case (ex_if.ForwardAE)
            2'b10:   src_a = m_q.alu_result;
            2'b01:   src_a = ex_if.ResultW;
            default: src_a = ex_if.SrcAE;
        endcase
        src_b_reg = ex_if.WriteDataE;
        case (ex_if.ForwardBE)
            2'b10:   src_b_reg = m_q.alu_result;
            2'b01:   src_b_reg = ex_if.ResultW;
            default: src_b_reg = ex_if.WriteDataE;
        endcase
    end
`else
    assign src_a     = ex_if.SrcAE;
    assign src_b_reg = ex_if.WriteDataE;
`endif

    assign src_b = ex_if.ALUSrcE ? ex_if.ExtImmE : src_b_reg;

    // ALU: subtraction is A + ~B + 1 so carry out means "no borrow".
    always_comb begin
        is_sub     = (alu_op_e'(ex_if.ALUControlE) == ALU_SUB);
        b_opnd     = is_sub ? ~src_b : src_b;
        sum        = {1'b0, src_a} + {1'b0, b_opnd} + {{WIDTH{1'b0}}, is_sub};
        alu_result = sum[WIDTH-1:0];
        alu_flags  = '0;
        case (alu_op_e'(ex_if.ALUControlE))
            ALU_ADD, ALU_SUB: begin
                alu_result  = sum[WIDTH-1:0];
                alu_flags.c = sum[WIDTH];
                alu_flags.v = (src_a[WIDTH-1] == b_opnd[WIDTH-1]) &&
                              (sum[WIDTH-1] != src_a[WIDTH-1]);
            end
            ALU_AND: alu_result = src_a & src_b;
            ALU_ORR: alu_result = src_a | src_b;
            default: alu_result = sum[WIDTH-1:0];
        endcase
        alu_flags.n = alu_result[WIDTH-1];
        alu_flags.z = (alu_result == '0);
    end

    execute_mem_stage_cond_check u_cond_check (
        .cond_i    (ex_if.CondE),
        .flags_i   (flags_q),
        .cond_ex_o (cond_ex)
    );

    assign exec_en = cond_ex & ~ex_if.FlushE;

    always_comb begin
        flags_d = flags_q;
        if (!ex_if.StallM && exec_en) begin
            if (ex_if.FlagWriteE[1]) begin
                flags_d.n = alu_flags.n;
                flags_d.z = alu_flags.z;
            end
            if (ex_if.FlagWriteE[0]) begin
                flags_d.c = alu_flags.c;
                flags_d.v = alu_flags.v;
            end
        end
    end

    // Stall holds everything; a flush only bubbles the gated controls.
    always_comb begin
        m_d = m_q;
        if (!ex_if.StallM) begin
            m_d.pcsrc      = ex_if.PCSrcE    & exec_en;
            m_d.regwrite   = ex_if.RegWriteE & exec_en;
            m_d.memwrite   = ex_if.MemWriteE & exec_en;
            m_d.memtoreg   = ex_if.MemtoRegE;
            m_d.alu_result = alu_result;
            m_d.write_data = src_b_reg;
            m_d.wa3        = ex_if.WA3E;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
            m_q     <= '0;
        end else begin
            flags_q <= flags_d;
            m_q     <= m_d;
        end
    end

    assign ex_if.BranchTakenE = ex_if.BranchE & exec_en;
    assign ex_if.ALUResultE   = alu_result;
    assign ex_if.FlagsQ       = flags_q;
    assign ex_if.PCSrcM       = m_q.pcsrc;
    assign ex_if.RegWriteM    = m_q.regwrite;
    assign ex_if.MemtoRegM    = m_q.memtoreg;
    assign ex_if.MemWriteM    = m_q.memwrite;
    assign ex_if.ALUResultM   = m_q.alu_result;
    assign ex_if.WriteDataM   = m_q.write_data;
    assign ex_if.WA3M         = m_q.wa3;

endmodule
